// File: rtl/cotm32_pkg.sv
// cotm32_pkg: shared constants and types for the cotm32 core and its MMIO
// peripherals.
//   XLEN            - data/address width.
//   CLINT_BASE_ADDR - byte base of the CLINT window.
//   CLINT_MEM_SIZE  - CLINT window size in bytes (power of two).
//   CLINT_AW        - CLINT byte-offset width.
//   clint_br_state_e- CLINT bridge FSM states.
//   mmio_req_t      - latched copy of an accepted core request.
package cotm32_pkg;

   localparam int unsigned     XLEN            = 32;
   localparam logic [XLEN-1:0] CLINT_BASE_ADDR = 32'h0200_0000;
   localparam logic [XLEN-1:0] CLINT_MEM_SIZE  = 32'h0001_0000;
   localparam int unsigned     CLINT_AW        = $clog2(CLINT_MEM_SIZE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } clint_br_state_e;

   // addr holds the byte offset into the CLINT window, not the full core
   // address: the window check happens at accept time, so only the offset
   // is needed afterwards.
   typedef struct packed {
      logic [CLINT_AW-1:0] addr;
      logic                we;
      logic [XLEN/8-1:0]   be;
      logic [XLEN-1:0]     wdata;
   } mmio_req_t;

endpackage

// File: rtl/mmio_byte_merge.sv
// mmio_byte_merge: combinational byte-lane merge for read-modify-write on
// word-only MMIO register ports.
//   i_old    - word currently held by the peripheral.
//   i_new    - lane-aligned store data.
//   i_be     - byte enables; lane k comes from i_new when i_be[k] is set.
//   o_merged - word to write back.
module mmio_byte_merge #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0]   i_old,
   input  logic [W-1:0]   i_new,
   input  logic [W/8-1:0] i_be,
   output logic [W-1:0]   o_merged
);

   always_comb begin
      o_merged = i_old;
      for (int k = 0; k < W/8; k++) begin
         if (i_be[k]) o_merged[8*k +: 8] = i_new[8*k +: 8];
      end
   end

endmodule

// File: rtl/clint_mmio_bridge.sv
// clint_mmio_bridge: converts core data-port loads/stores in the CLINT window
// into the CLINT's word-wide register port, doing read-modify-write for
// sub-word stores. One response per request; err flags out-of-window or
// misaligned accesses.
//   i_clk, i_rst        - clock, synchronous active-low reset.
//   i_req_* / o_req_ready   - core request channel (valid/ready).
//   o_resp_* / i_resp_ready - core response channel (valid/ready).
//   o_clint_addr/we/wdata   - CLINT register port outputs.
//   i_clint_rdata           - CLINT read data, combinational from o_clint_addr.
module clint_mmio_bridge #(
   parameter int unsigned      XLEN       = cotm32_pkg::XLEN,
   parameter logic [XLEN-1:0]  CLINT_BASE = cotm32_pkg::CLINT_BASE_ADDR,
   parameter logic [XLEN-1:0]  CLINT_SIZE = cotm32_pkg::CLINT_MEM_SIZE,
   parameter int unsigned      CLINT_AW   = $clog2(CLINT_SIZE)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_req_valid,
   output logic                o_req_ready,
   input  logic [XLEN-1:0]     i_req_addr,
   input  logic                i_req_we,
   input  logic [XLEN/8-1:0]   i_req_be,
   input  logic [XLEN-1:0]     i_req_wdata,
   output logic                o_resp_valid,
   input  logic                i_resp_ready,
   output logic [XLEN-1:0]     o_resp_rdata,
   output logic                o_resp_err,
   output logic [CLINT_AW-1:0] o_clint_addr,
   output logic                o_clint_we,
   output logic [XLEN-1:0]     o_clint_wdata,
   input  logic [XLEN-1:0]     i_clint_rdata
);

   import cotm32_pkg::*;

   clint_br_state_e state_q, state_d;
   mmio_req_t       req_q, req_d;
   logic [XLEN-1:0] cap_q, cap_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            err_q, err_d;
   logic [XLEN-1:0] req_off;
   logic            req_fault;
   logic            accept;
   logic [XLEN-1:0] merged;

   // Unsigned wrap: an address below the base becomes a huge offset and
   // fails the size check as well.
   assign req_off   = i_req_addr - CLINT_BASE;
   assign req_fault = (i_req_addr < CLINT_BASE) || (req_off >= CLINT_SIZE) ||
                      (i_req_addr[1:0] != 2'b00);

   assign o_req_ready  = i_rst && (state_q == IDLE);
   assign accept       = i_req_valid && o_req_ready;
   assign o_resp_valid = (state_q == RESP);
   assign o_resp_rdata = rdata_q;
   assign o_resp_err   = err_q;

   mmio_byte_merge #(.W(XLEN)) u_merge (
      .i_old    (cap_q),
      .i_new    (req_q.wdata),
      .i_be     (req_q.be),
      .o_merged (merged)
   );

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      cap_d   = cap_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               req_d.addr  = req_off[CLINT_AW-1:0];
               req_d.we    = i_req_we;
               req_d.be    = i_req_be;
               req_d.wdata = i_req_wdata;
               rdata_d     = '0;
               err_d       = 1'b0;
               if (req_fault) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else if (!i_req_we) begin
                  state_d = RD;
               end else if (&i_req_be) begin
                  state_d = WR;
               end else if (i_req_be == '0) begin
                  state_d = RESP;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            cap_d = i_clint_rdata;
            if (req_q.we) begin
               state_d = WR;
            end else begin
               rdata_d = i_clint_rdata;
               state_d = RESP;
            end
         end
         WR:      state_d = RESP;
         RESP:    if (i_resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Only aligned in-window requests reach RD/WR, so the latched offset
   // already has its low two bits clear.
   always_comb begin
      o_clint_addr  = '0;
      o_clint_we    = 1'b0;
      o_clint_wdata = '0;
      if (state_q == RD) begin
         o_clint_addr = req_q.addr;
      end else if (state_q == WR) begin
         o_clint_addr  = req_q.addr;
         o_clint_we    = i_rst;
         o_clint_wdata = merged;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q <= IDLE;
         req_q   <= '0;
         cap_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         cap_q   <= cap_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

endmodule
